// File: rtl/aes_arb_pkg.sv
// Shared constants for the AES core arbiter: datapath width and FSM encodings.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package aes_arb_pkg;

    localparam int AES_W = 128;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] BUSY  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

endpackage

// File: rtl/aes_arb_if.sv
// Requester-side bundle of the AES arbiter: job request and result return channels.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both the job and the result channel.
interface aes_arb_if #(
    parameter int NREQ = 2
);
    import aes_arb_pkg::*;

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*AES_W-1:0] req_plaintext;
    logic [NREQ*AES_W-1:0] req_key;
    logic [NREQ-1:0]       rsp_valid;
    logic [NREQ-1:0]       rsp_ready;
    logic [AES_W-1:0]      rsp_ciphertext;
    logic                  rsp_err;

    // Requesters drive jobs and consume results.
    modport master (
        output req_valid, req_plaintext, req_key, rsp_ready,
        input  req_ready, rsp_valid, rsp_ciphertext, rsp_err
    );

    // The arbiter accepts jobs and returns results.
    modport slave (
        input  req_valid, req_plaintext, req_key, rsp_ready,
        output req_ready, rsp_valid, rsp_ciphertext, rsp_err
    );

endinterface

// File: rtl/aes_rr_pick.sv
// Round-robin picker: first asserted request at or above ptr, wrapping modulo NREQ.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the winner is granted.
module aes_rr_pick #(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      ptr,
    output logic [1:0]      winner,
    output logic            any
);

    // Walk the requesters starting at ptr; the first hit wins.
    always_comb begin
        logic [2:0] idx;
        idx    = '0;
        winner = 2'd0;
        any    = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, ptr} + 3'(k);
            if (idx >= 3'(NREQ)) begin
                idx = idx - 3'(NREQ);
            end
            for (int i = 0; i < NREQ; i++) begin
                if (!any && idx == 3'(i) && req[i]) begin
                    any    = 1'b1;
                    winner = 2'(i);
                end
            end
        end
    end

endmodule

// File: rtl/aes_arb.sv
// Shares one iterative AES-128 core among NREQ requesters with round-robin grant and a watchdog.
// Latency: accept at T, aes_start at T+1, response at T+2+L (L = core latency) or start+TIMEOUT on abort.
// Backpressure: no grant unless idle and aes_ready; a response is held until its owner's rsp_ready.
module aes_arb
    import aes_arb_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    aes_arb_if.slave         bus,
    output logic             aes_start,
    input  logic             aes_ready,
    input  logic             aes_valid,
    output logic [AES_W-1:0] aes_plaintext,
    output logic [AES_W-1:0] aes_key,
    input  logic [AES_W-1:0] aes_ciphertext,
    output logic             busy,
    output logic [1:0]       owner
);

    // Watchdog width: one bit of headroom above TIMEOUT-1 so the compare never sees a wrap.
    function automatic int wdog_width(input int limit);
        return $clog2(limit) + 1;
    endfunction

    localparam int CW = wdog_width(TIMEOUT);

    logic [1:0]       state;
    logic [1:0]       ptr;
    logic [1:0]       winner;
    logic             any;
    logic [AES_W-1:0] pt_q;
    logic [AES_W-1:0] key_q;
    logic [AES_W-1:0] result;
    logic             err_q;
    logic [CW-1:0]    wdog;
    logic [CW-1:0]    wdog_nxt;
    logic             timeout;
    logic [NREQ-1:0]  grant_oh;
    logic [NREQ-1:0]  own_oh;
    logic [AES_W-1:0] sel_pt;
    logic [AES_W-1:0] sel_key;
    logic [1:0]       next_ptr;
    logic             accept;
    logic             rsp_mine;

    aes_rr_pick #(.NREQ(NREQ)) u_pick (
        .req    (bus.req_valid),
        .ptr    (ptr),
        .winner (winner),
        .any    (any)
    );

    // One-hot views of the winner and owner, plus the winner's job data mux.
    always_comb begin
        grant_oh = '0;
        own_oh   = '0;
        sel_pt   = '0;
        sel_key  = '0;
        for (int i = 0; i < NREQ; i++) begin
            grant_oh[i] = (winner == 2'(i));
            own_oh[i]   = (owner == 2'(i));
            if (winner == 2'(i)) begin
                sel_pt  = bus.req_plaintext[i*AES_W +: AES_W];
                sel_key = bus.req_key[i*AES_W +: AES_W];
            end
        end
    end

    // Grant only while idle and the core can take a start, so a stale completion never reaches a new owner.
    assign bus.req_ready      = (state == IDLE && aes_ready && any) ? grant_oh : '0;
    assign bus.rsp_valid      = (state == RESP) ? own_oh : '0;
    assign bus.rsp_ciphertext = result;
    assign bus.rsp_err        = err_q;

    assign accept   = |(bus.req_valid & bus.req_ready);
    assign rsp_mine = |(bus.rsp_ready & own_oh);
    assign next_ptr = (owner == 2'(NREQ - 1)) ? 2'd0 : owner + 2'd1;
    assign wdog_nxt = wdog + CW'(1);
    assign timeout  = (wdog_nxt == CW'(TIMEOUT - 1));

    assign aes_start     = (state == START);
    assign aes_plaintext = pt_q;
    assign aes_key       = key_q;
    assign busy          = (state != IDLE);

    // Sequencer: latch job, pulse start, wait for completion or watchdog, hold result until consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= 2'd0;
            owner  <= 2'd0;
            pt_q   <= '0;
            key_q  <= '0;
            result <= '0;
            err_q  <= 1'b0;
            wdog   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        pt_q  <= sel_pt;
                        key_q <= sel_key;
                        owner <= winner;
                        state <= START;
                    end
                end
                START: begin
                    wdog  <= '0;
                    state <= BUSY;
                end
                BUSY: begin
                    // A completion in the same cycle as the timeout still counts as success.
                    if (aes_valid) begin
                        result <= aes_ciphertext;
                        err_q  <= 1'b0;
                        state  <= RESP;
                    end else if (timeout) begin
                        result <= '0;
                        err_q  <= 1'b1;
                        state  <= RESP;
                    end else if (wdog != '1) begin
                        wdog <= wdog_nxt;
                    end
                end
                RESP: begin
                    if (rsp_mine) begin
                        ptr   <= next_ptr;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_arb.sv
// Self-checking bench for aes_arb with a behavioural core model and a response scoreboard.
// Latency: core model completes LAT cycles after aes_start unless told to hang.
// Backpressure: rsp_ready and aes_ready are driven per scenario.
module tb_aes_arb;
    import aes_arb_pkg::*;

    localparam int NREQ    = 2;
    localparam int TIMEOUT = 20;
    localparam int LAT     = 10;

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst;
    logic         aes_start;
    logic         aes_ready;
    logic         aes_valid;
    logic [127:0] aes_plaintext;
    logic [127:0] aes_key;
    logic [127:0] aes_ciphertext;
    logic         busy;
    logic [1:0]   owner;

    always #5 clk = ~clk;

    aes_arb_if #(.NREQ(NREQ)) bus ();

    aes_arb #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .aes_start      (aes_start),
        .aes_ready      (aes_ready),
        .aes_valid      (aes_valid),
        .aes_plaintext  (aes_plaintext),
        .aes_key        (aes_key),
        .aes_ciphertext (aes_ciphertext),
        .busy           (busy),
        .owner          (owner)
    );

    // Core stand-in: the known FIPS-197 vector, otherwise a cheap distinct mix of plaintext and key.
    function automatic logic [127:0] core_fn(input logic [127:0] pt, input logic [127:0] key);
        if (pt == FIPS_PT && key == FIPS_KEY) return FIPS_CT;
        return pt ^ {key[63:0], key[127:64]} ^ 128'ha5a5_5a5a_c3c3_3c3c_0ff0_f00f_1234_8765;
    endfunction

    logic         core_busy;
    logic         core_vld;
    logic         core_hang;
    logic         core_block;
    int           core_cnt;
    logic [127:0] core_pt;
    logic [127:0] core_key;
    logic [127:0] core_ct;

    assign aes_ready      = !core_busy && !core_block;
    assign aes_valid      = core_vld;
    assign aes_ciphertext = core_ct;

    // Iterative core model sharing the arbiter reset.
    always @(posedge clk) begin
        if (rst) begin
            core_busy <= 1'b0;
            core_vld  <= 1'b0;
            core_cnt  <= 0;
            core_ct   <= '0;
        end else begin
            core_vld <= 1'b0;
            if (aes_start && !core_busy) begin
                core_busy <= 1'b1;
                core_cnt  <= 1;
                core_pt   <= aes_plaintext;
                core_key  <= aes_key;
            end else if (core_busy) begin
                if (!core_hang && core_cnt >= LAT - 1) begin
                    core_vld  <= 1'b1;
                    core_ct   <= core_fn(core_pt, core_key);
                    core_busy <= 1'b0;
                end else begin
                    core_cnt <= core_cnt + 1;
                end
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        int           idx;
        logic [127:0] ct;
        logic         err;
    } exp_t;

    exp_t sbq[$];

    // Scoreboard monitor: every completed response handshake pops one expectation.
    always @(negedge clk) begin
        if (!rst && (bus.rsp_valid & bus.rsp_ready) != '0) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rsp: rsp_valid=%b with nothing expected", bus.rsp_valid);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("rsp_owner", 128'(bus.rsp_valid), 128'(1) << e.idx);
                check("rsp_ciphertext", bus.rsp_ciphertext, e.ct);
                check("rsp_err", 128'(bus.rsp_err), 128'(e.err));
            end
        end
    end

    logic late_seen = 1'b0;
    always @(negedge clk) begin
        if (aes_valid && !busy) late_seen = 1'b1;
    end

    task automatic set_req(input int i, input logic [127:0] pt, input logic [127:0] key);
        if (i == 0) begin
            bus.req_plaintext[127:0] = pt;
            bus.req_key[127:0]       = key;
        end else begin
            bus.req_plaintext[255:128] = pt;
            bus.req_key[255:128]       = key;
        end
    endtask

    // Wait at negedges for a job handshake; report requester index and cycle.
    task automatic wait_accept(input string nm, output int idx, output int t);
        int n;
        logic [NREQ-1:0] g;
        idx = -1;
        t   = -1;
        for (n = 0; n < 300; n++) begin
            @(negedge clk);
            if ((bus.req_valid & bus.req_ready) != '0) break;
        end
        check({nm, "_accept_seen"}, 128'(n < 300), 128'(1));
        if (n < 300) begin
            g   = bus.req_valid & bus.req_ready;
            idx = g[1] ? 1 : 0;
            t   = cyc;
        end
    endtask

    task automatic wait_rsp(input string nm, output int t);
        int n;
        t = -1;
        for (n = 0; n < 300; n++) begin
            @(negedge clk);
            if (bus.rsp_valid != '0) break;
        end
        check({nm, "_rsp_seen"}, 128'(n < 300), 128'(1));
        if (n < 300) t = cyc;
    endtask

    task automatic wait_drain(input string nm);
        int n;
        for (n = 0; n < 500; n++) begin
            @(negedge clk);
            if (sbq.size() == 0 && !busy) break;
        end
        check({nm, "_drained"}, 128'(n < 500), 128'(1));
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, "_req_ready"}, 128'(bus.req_ready), 128'(0));
        check({nm, "_rsp_valid"}, 128'(bus.rsp_valid), 128'(0));
        check({nm, "_rsp_err"}, 128'(bus.rsp_err), 128'(0));
        check({nm, "_aes_start"}, 128'(aes_start), 128'(0));
        check({nm, "_busy"}, 128'(busy), 128'(0));
        check({nm, "_owner"}, 128'(owner), 128'(0));
        check({nm, "_rsp_ct"}, bus.rsp_ciphertext, 128'(0));
        check({nm, "_aes_pt"}, aes_plaintext, 128'(0));
        check({nm, "_aes_key"}, aes_key, 128'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish at time %0t", $time);
        $fatal(1, "global timeout");
    end

    localparam logic [127:0] P0 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [127:0] K0 = 128'h0f0e_0d0c_0b0a_0908_0706_0504_0302_0100;
    localparam logic [127:0] P1 = 128'hdead_beef_cafe_f00d_0123_4567_89ab_cdef;
    localparam logic [127:0] K1 = 128'hffee_ddcc_bbaa_9988_7766_5544_3322_1100;
    localparam logic [127:0] P2 = 128'h0000_0000_0000_0000_ffff_ffff_ffff_ffff;
    localparam logic [127:0] K2 = 128'h8000_0000_0000_0000_0000_0000_0000_0001;
    localparam logic [127:0] P3 = 128'h0102_0304_0506_0708_090a_0b0c_0d0e_0f10;
    localparam logic [127:0] K3 = 128'h2b7e_1516_28ae_d2a6_abf7_1588_09cf_4f3c;
    localparam logic [127:0] P4 = 128'h3243_f6a8_885a_308d_3131_98a2_e037_0734;
    localparam logic [127:0] K4 = 128'h5555_aaaa_5555_aaaa_5555_aaaa_5555_aaaa;
    localparam logic [127:0] P5 = 128'h7777_7777_0000_0000_7777_7777_0000_0000;
    localparam logic [127:0] K5 = 128'h1357_9bdf_0246_8ace_1357_9bdf_0246_8ace;

    initial begin
        int idx;
        int t_acc;
        int t_rsp;

        rst               = 1'b1;
        core_hang         = 1'b0;
        core_block        = 1'b0;
        bus.req_valid     = '0;
        bus.req_plaintext = '0;
        bus.req_key       = '0;
        bus.rsp_ready     = 2'b11;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        // Contention from ptr=0: grants alternate 0,1,0,1, each with its own data.
        set_req(0, P0, K0);
        set_req(1, P1, K1);
        sbq.push_back('{idx: 0, ct: core_fn(P0, K0), err: 1'b0});
        sbq.push_back('{idx: 1, ct: core_fn(P1, K1), err: 1'b0});
        sbq.push_back('{idx: 0, ct: core_fn(P0, K0), err: 1'b0});
        sbq.push_back('{idx: 1, ct: core_fn(P1, K1), err: 1'b0});
        bus.req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_accept("contend", idx, t_acc);
            check("grant_order", 128'(idx), 128'(k % 2));
        end
        @(posedge clk);
        #1 bus.req_valid = '0;
        wait_drain("contend");

        // Single FIPS-197 job on requester 0 with latency checks.
        sbq.push_back('{idx: 0, ct: FIPS_CT, err: 1'b0});
        @(posedge clk);
        #1;
        set_req(0, FIPS_PT, FIPS_KEY);
        bus.req_valid = 2'b01;
        wait_accept("single", idx, t_acc);
        check("single_grant", 128'(idx), 128'(0));
        @(posedge clk);
        #1 bus.req_valid = '0;
        @(negedge clk);
        check("single_start_pulse", 128'(aes_start), 128'(1));
        check("single_core_pt", aes_plaintext, FIPS_PT);
        check("single_core_key", aes_key, FIPS_KEY);
        wait_rsp("single", t_rsp);
        check("single_latency", 128'(t_rsp - t_acc), 128'(2 + LAT));
        wait_drain("single");

        // Core not ready: requester 1 waits, no grant and no start.
        @(posedge clk);
        #1;
        core_block = 1'b1;
        set_req(1, P2, K2);
        bus.req_valid = 2'b10;
        repeat (10) begin
            @(negedge clk);
            check("notready_req_ready", 128'(bus.req_ready), 128'(0));
            check("notready_start", 128'(aes_start), 128'(0));
        end
        @(posedge clk);
        #1 core_block = 1'b0;
        sbq.push_back('{idx: 1, ct: core_fn(P2, K2), err: 1'b0});
        wait_accept("notready", idx, t_acc);
        check("notready_grant", 128'(idx), 128'(1));
        @(posedge clk);
        #1 bus.req_valid = '0;
        wait_drain("notready");

        // Backpressure: requester 0 holds off its result for 20 cycles; requester 1 waits.
        @(posedge clk);
        #1;
        bus.rsp_ready = 2'b10;
        sbq.push_back('{idx: 0, ct: core_fn(P3, K3), err: 1'b0});
        set_req(0, P3, K3);
        bus.req_valid = 2'b01;
        wait_accept("bp", idx, t_acc);
        @(posedge clk);
        #1;
        set_req(1, P4, K4);
        bus.req_valid = 2'b10;
        wait_rsp("bp", t_rsp);
        for (int k = 0; k < 20; k++) begin
            if (k > 0) @(negedge clk);
            check("bp_rsp_valid", 128'(bus.rsp_valid), 128'(2'b01));
            check("bp_rsp_ct", bus.rsp_ciphertext, core_fn(P3, K3));
            check("bp_req_ready", 128'(bus.req_ready), 128'(0));
        end
        @(posedge clk);
        #1;
        bus.rsp_ready = 2'b11;
        sbq.push_back('{idx: 1, ct: core_fn(P4, K4), err: 1'b0});
        @(negedge clk);
        @(negedge clk);
        check("bp_idle_after", 128'(busy), 128'(0));
        check("bp_next_grant", 128'(bus.req_ready), 128'(2'b10));
        @(posedge clk);
        #1 bus.req_valid = '0;
        wait_drain("bp");

        // Watchdog: core never completes; abort with err and zero data, late pulse ignored.
        @(posedge clk);
        #1;
        core_hang = 1'b1;
        sbq.push_back('{idx: 0, ct: 128'(0), err: 1'b1});
        set_req(0, P5, K5);
        bus.req_valid = 2'b01;
        wait_accept("wdog", idx, t_acc);
        @(posedge clk);
        #1 bus.req_valid = '0;
        wait_rsp("wdog", t_rsp);
        check("wdog_latency", 128'(t_rsp - (t_acc + 1)), 128'(TIMEOUT));
        wait_drain("wdog");
        @(posedge clk);
        #1 core_hang = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check("wdog_late_rsp_valid", 128'(bus.rsp_valid), 128'(0));
            check("wdog_late_busy", 128'(busy), 128'(0));
        end
        check("wdog_late_pulse_seen", 128'(late_seen), 128'(1));

        // Mid-operation reset two cycles after aes_start, then a fresh job.
        @(posedge clk);
        #1;
        set_req(1, P1, K1);
        bus.req_valid = 2'b10;
        wait_accept("midrst", idx, t_acc);
        @(posedge clk);
        #1 bus.req_valid = '0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrst");
        repeat (5) begin
            @(negedge clk);
            check("midrst_no_rsp", 128'(bus.rsp_valid), 128'(0));
        end
        @(posedge clk);
        #1;
        sbq.push_back('{idx: 0, ct: FIPS_CT, err: 1'b0});
        set_req(0, FIPS_PT, FIPS_KEY);
        set_req(1, P2, K2);
        bus.req_valid = 2'b11;
        wait_accept("fresh", idx, t_acc);
        check("fresh_grant_after_reset", 128'(idx), 128'(0));
        @(posedge clk);
        #1 bus.req_valid = '0;
        wait_drain("fresh");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
